// File: rtl/hex_display_io.sv
// -----------------------------------------------------------------------------
// hex_display_io
//
// Memory-mapped HEX display device sitting on the processor data bus.
// Holds a 16-bit display value and a control word (digit mask + blink enable),
// both written by stores and readable by loads. A free-running divider
// produces a blink phase that, when blinking is enabled, gates the digit
// enables on and off with a half-period of BLINK_DIV clock cycles.
//
// Parameters:
//   ADDR_HEX   address of the display-value register
//   ADDR_CTRL  address of the control register (MASK[3:0], BLINK[4])
//   BLINK_DIV  clock cycles per blink half-period (>= 2)
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset
//   abus      in   32-bit byte address from the memory stage
//   wdata     in   32-bit store data
//   we        in   store strobe
//   re        in   load strobe
//   rdata     out  32-bit load data, 0 when this device is not selected
//   hex_val   out  16-bit display value, nibble i feeds digit i decoder
//   digit_en  out  per-digit lit enable (0 = blanked at the top level)
// -----------------------------------------------------------------------------
module hex_display_io #(
  parameter logic [31:0] ADDR_HEX  = 32'hFFFF_F000,
  parameter logic [31:0] ADDR_CTRL = 32'hFFFF_F004,
  parameter int          BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] abus,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [15:0] hex_val,
  output logic [3:0]  digit_en
);

  // Counter width; a divider of 2 still needs one bit.
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [15:0]   hex_q,   hex_d;
  logic [3:0]    mask_q,  mask_d;
  logic          blink_q, blink_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    en_q,    en_d;

  logic hex_sel_s;
  logic ctrl_sel_s;
  logic hex_wr_s;
  logic ctrl_wr_s;
  logic restart_s;
  logic unused_wdata_s;

  // Full 32-bit address decode.
  assign hex_sel_s  = (abus == ADDR_HEX);
  assign ctrl_sel_s = (abus == ADDR_CTRL);
  assign hex_wr_s   = we & hex_sel_s;
  assign ctrl_wr_s  = we & ctrl_sel_s;

  // Blink restart only on a 0 -> 1 transition of BLINK; rewriting BLINK=1
  // must leave the running phase alone.
  assign restart_s  = ctrl_wr_s & wdata[4] & ~blink_q;

  // Upper store-data bits carry no meaning for this device.
  assign unused_wdata_s = ^wdata[31:16];

  // Next-state logic for registers, blink divider and digit enables.
  always_comb begin
    hex_d   = hex_q;
    mask_d  = mask_q;
    blink_d = blink_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    en_d    = en_q;

    if (hex_wr_s) begin
      hex_d = wdata[15:0];
    end else begin
      hex_d = hex_q;
    end

    if (ctrl_wr_s) begin
      mask_d  = wdata[3:0];
      blink_d = wdata[4];
    end else begin
      mask_d  = mask_q;
      blink_d = blink_q;
    end

    // Free-running divider; the restart overrides a coincident toggle.
    if (restart_s) begin
      cnt_d   = {CW{1'b0}};
      phase_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = {CW{1'b0}};
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
    end

    // Enables are computed from next-state values so the registered output
    // tracks the register contents with no extra cycle of delay.
    if (blink_d) begin
      en_d = mask_d & {4{phase_d}};
    end else begin
      en_d = mask_d;
    end

    if (reset) begin
      hex_d   = 16'h0000;
      mask_d  = 4'hF;
      blink_d = 1'b0;
      cnt_d   = {CW{1'b0}};
      phase_d = 1'b1;
      en_d    = 4'hF;
    end else begin
      en_d    = en_d;
    end
  end

  // State registers; reset handling is folded into the next-state values.
  always_ff @(posedge clk) begin
    hex_q   <= hex_d;
    mask_q  <= mask_d;
    blink_q <= blink_d;
    cnt_q   <= cnt_d;
    phase_q <= phase_d;
    en_q    <= en_d;
  end

  // Combinational load data; zero when not selected so it can be OR-ed.
  always_comb begin
    rdata = 32'h0000_0000;
    if (re && hex_sel_s) begin
      rdata = {16'h0000, hex_q};
    end else if (re && ctrl_sel_s) begin
      rdata = {27'h000_0000, blink_q, mask_q};
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign hex_val  = hex_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_hex_display_io.sv
// -----------------------------------------------------------------------------
// Bench for hex_display_io (BLINK_DIV = 4): reset check, a table of directed
// vectors, hand-written multi-cycle corner cases and a randomized phase
// compared against a time-based reference model.
// -----------------------------------------------------------------------------
module tb_hex_display_io;

  localparam logic [31:0] A_HEX  = 32'hFFFF_F000;
  localparam logic [31:0] A_CTRL = 32'hFFFF_F004;
  localparam logic [31:0] A_OTH  = 32'hFFFF_F008;
  localparam int          DIV    = 4;

  logic        clk;
  logic        reset;
  logic [31:0] abus;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [15:0] hex_val;
  logic [3:0]  digit_en;

  int total = 0;
  int bad   = 0;

  hex_display_io #(
    .ADDR_HEX (A_HEX),
    .ADDR_CTRL(A_CTRL),
    .BLINK_DIV(DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .abus    (abus),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .hex_val (hex_val),
    .digit_en(digit_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents plus the edge count at which the
  // blink phase last started; phase is derived from elapsed edges.
  logic [15:0] m_hex;
  logic [3:0]  m_mask;
  logic        m_blink;
  int          edge_n  = 0;
  int          m_epoch = 0;

  function automatic logic [3:0] m_en();
    logic on;
    on = (((edge_n - m_epoch) / DIV) % 2) == 0;
    if (m_blink) return m_mask & {4{on}};
    return m_mask;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (re && abus == A_HEX)  return {16'h0000, m_hex};
    if (re && abus == A_CTRL) return {27'h0, m_blink, m_mask};
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    edge_n++;
    if (reset) begin
      m_hex = 16'h0; m_mask = 4'hF; m_blink = 1'b0; m_epoch = edge_n;
    end else if (we) begin
      if (abus == A_HEX) m_hex = wdata[15:0];
      if (abus == A_CTRL) begin
        if (wdata[4] && !m_blink) m_epoch = edge_n;
        m_mask  = wdata[3:0];
        m_blink = wdata[4];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; abus = a; wdata = d;
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // before the edge
    logic [15:0] exp_hex;    // after the edge
    logic [3:0]  exp_en;     // after the edge
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic [15:0] eh, input logic [3:0] ee);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_hex = eh; v.exp_en = ee;
    return v;
  endfunction

  vec_t vecs[18];
  logic [3:0] nr_exp[9];

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, A_HEX,  32'hDEAD_BEEF, 32'h0,         16'hBEEF, 4'hF);
    vecs[1]  = mk(1'b0, 1'b1, A_HEX,  32'h0,         32'h0000_BEEF, 16'hBEEF, 4'hF);
    vecs[2]  = mk(1'b0, 1'b1, A_OTH,  32'h0,         32'h0,         16'hBEEF, 4'hF);
    vecs[3]  = mk(1'b1, 1'b1, A_OTH,  32'hFFFF_FFFF, 32'h0,         16'hBEEF, 4'hF);
    vecs[4]  = mk(1'b1, 1'b0, A_CTRL, 32'h0000_0015, 32'h0,         16'hBEEF, 4'h5);
    vecs[5]  = mk(1'b0, 1'b1, A_CTRL, 32'h0,         32'h0000_0015, 16'hBEEF, 4'h5);
    vecs[6]  = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[7]  = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[8]  = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h0);
    vecs[9]  = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h0);
    vecs[10] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h0);
    vecs[11] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h0);
    vecs[12] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[13] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[14] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[15] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h5);
    vecs[16] = mk(1'b0, 1'b0, A_HEX,  32'h0,         32'h0,         16'hBEEF, 4'h0);
    vecs[17] = mk(1'b1, 1'b0, A_CTRL, 32'h0000_000A, 32'h0,         16'hBEEF, 4'hA);

    // Non-restart rewrite: 0x11 at step 0, 0x1F at step 2; toggle stays on step 4.
    nr_exp = '{4'h1, 4'h1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};

    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    m_hex = 16'h0; m_mask = 4'hF; m_blink = 1'b0;

    // 1. reset
    tick();
    tick();
    set_in(1'b0, 1'b1, A_HEX, 32'h0);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_hex", {16'h0, hex_val}, 32'h0);
    check("reset_en", {28'h0, digit_en}, 32'hF);
    reset = 1'b0;

    // 2-4. table-driven vectors
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      tick();
      check($sformatf("vec%0d_hex", i), {16'h0, hex_val}, {16'h0, vecs[i].exp_hex});
      check($sformatf("vec%0d_en", i), {28'h0, digit_en}, {28'h0, vecs[i].exp_en});
    end

    // 4. blink off holds for 20 cycles
    set_in(1'b0, 1'b0, A_HEX, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("blinkoff_en%0d", i), {28'h0, digit_en}, 32'hA);
    end

    // 5a. reset beats a same-cycle write
    reset = 1'b1;
    set_in(1'b1, 1'b0, A_HEX, 32'h0000_1234);
    tick();
    reset = 1'b0;
    check("prio_reset_hex", {16'h0, hex_val}, 32'h0);
    check("prio_reset_en", {28'h0, digit_en}, 32'hF);

    // 5b. same-cycle read and write
    set_in(1'b1, 1'b0, A_HEX, 32'h0000_ABCD);
    tick();
    set_in(1'b1, 1'b1, A_HEX, 32'h0000_5678);
    #1;
    check("rw_old_rdata", rdata, 32'h0000_ABCD);
    tick();
    set_in(1'b0, 1'b1, A_HEX, 32'h0);
    #1;
    check("rw_new_rdata", rdata, 32'h0000_5678);

    // 6. rewrite with BLINK already set does not restart the phase
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      set_in(1'b1, 1'b0, A_CTRL, 32'h0000_0011);
      else if (i == 2) set_in(1'b1, 1'b0, A_CTRL, 32'h0000_001F);
      else             set_in(1'b0, 1'b0, A_HEX, 32'h0);
      tick();
      check($sformatf("norestart_en%0d", i), {28'h0, digit_en}, {28'h0, nr_exp[i]});
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = A_HEX;
        1: a = A_CTRL;
        2: a = A_OTH;
        default: a = $urandom;
      endcase
      reset = ($urandom_range(0, 59) == 0);
      set_in(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, a,
             ($urandom_range(0, 1) == 1) ? $urandom : {$urandom} & 32'h1F);
      #1;
      check("rand_rdata", rdata, m_rdata());
      tick();
      check("rand_hex", {16'h0, hex_val}, {16'h0, m_hex});
      check("rand_en", {28'h0, digit_en}, {28'h0, m_en()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_io.md
# hex_display_io

Memory-mapped HEX display device on the processor's data bus. It holds a 16-bit display value and a control word written by stores. It drives the four nibbles consumed by the four per-digit hex-to-7-segment decoders, plus a per-digit enable used at the top level to blank digits. A free-running divider provides an optional blink function.

## Interface
- `ADDR_HEX`, default 32'hFFFFF000: address of the display-value register.
- `ADDR_CTRL`, default 32'hFFFFF004: address of the control register.
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period; must be ≥2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `abus`  in  32  byte address from the memory stage.
- `wdata`  in  32  store data.
- `we`  in  1  store strobe, one cycle per store.
- `re`  in  1  load strobe.
- `rdata`  out  32  load data; OR-bus contribution, 0 when not selected.
- `hex_val`  out  16  nibble i (bits 4i+3:4i) drives decoder for HEX digit i.
- `digit_en`  out  4  bit i = 1 means digit i is lit. When 0, the top level forces that digit's segments to 7'h7F.

## Operation
- Registers:
  - HEX[15:0].
  - CTRL: MASK[3:0] at CTRL bits 3:0; BLINK at CTRL bit 4.
  - Blink counter `cnt`, width clog2(BLINK_DIV).
  - `phase` bit: 1 = on half-period.
- Reset values: HEX=16'h0000, MASK=4'hF, BLINK=0, cnt=0, phase=1. Resulting outputs: hex_val=0, digit_en=4'hF, rdata=0.
- Write to HEX: `we` && abus==ADDR_HEX → HEX ← wdata[15:0]. wdata[31:16] is ignored.
- Write to CTRL: `we` && abus==ADDR_CTRL → MASK ← wdata[3:0], BLINK ← wdata[4]. wdata[31:5] is ignored.
- Address decode is a full 32-bit compare. Any other address: no state change, rdata=0.
- Reads are combinational:
  - `re` && abus==ADDR_HEX → rdata = {16'h0, HEX}.
  - `re` && abus==ADDR_CTRL → rdata = {27'h0, BLINK, MASK}.
  - Otherwise rdata=0.
- Blink counter:
  - cnt increments every cycle.
  - At cnt==BLINK_DIV-1: cnt←0 and phase toggles.
  - Runs regardless of BLINK.
- Blink restart: a CTRL write that changes BLINK from 0 to 1 sets cnt←0, phase←1. The display is therefore visible immediately for a full half-period. A CTRL write leaving BLINK at 1 does not disturb cnt or phase.
- Outputs:
  - hex_val = HEX.
  - digit_en = MASK when BLINK=0.
  - digit_en = MASK & {4{phase}} when BLINK=1.

## Timing
- Store latency: register value and outputs change on the edge that samples `we`, visible the next cycle.
- Load latency: zero cycles, combinational from abus, `re` and register state.
- Simultaneous `re` and `we` to the same address: rdata shows the old value, and the new value is stored at the edge.
- `we` and `re` held for multiple cycles are legal. Repeated writes of the same data are idempotent.
- Reset has priority over any write in the same cycle. Reset mid-blink forces phase=1 and cnt=0 on that edge.
- Phase period is exactly 2·BLINK_DIV cycles. The first toggle after reset or blink restart occurs BLINK_DIV cycles later.
- No wrap hazard: cnt never exceeds BLINK_DIV-1.

## Test plan
Benches use BLINK_DIV=4.
1. Reset check: assert reset for 2 cycles → hex_val=16'h0000, digit_en=4'hF, rdata=0 with re=1 at ADDR_HEX.
2. HEX write and readback:
   - Write wdata=32'hDEAD_BEEF to ADDR_HEX.
   - Next cycle: hex_val=16'hBEEF.
   - Load at ADDR_HEX → rdata=32'h0000_BEEF.
   - Load at 32'hFFFFF008 → rdata=0.
3. Mask and blink:
   - Write 32'h15 to ADDR_CTRL → digit_en=4'h5 for 4 cycles, 4'h0 for 4 cycles, then 4'h5 again.
   - Load at ADDR_CTRL → rdata=32'h15.
4. Blink off: write 32'h0A to ADDR_CTRL mid off-phase → digit_en=4'hA the next cycle and stays there for 20 cycles.
5. Priority:
   - Assert reset and a write of 32'h1234 to ADDR_HEX in the same cycle → hex_val=0.
   - Same-cycle read and write of 16'h5678 at ADDR_HEX → rdata shows the old value that cycle and 32'h5678 the next.
6. Non-restart rewrite: with BLINK=1, rewrite CTRL=32'h1F mid-period → phase sequence is not restarted, and the toggle occurs at the original cycle.
